cacop_ctrl: RTL and testbench
=============================

# cacop_ctrl

Sequencer for CACOP cache-maintenance operations issued from the EXE stage. It captures a CACOP request (code, virtual and physical address, translation fault) and decodes the target cache and operation. It issues a single request/ready handshake to the icache or dcache maintenance port, then waits for that cache's completion. It returns a one-cycle `cacop_ok` that releases the EXE stage, and drains in-flight operations safely across pipeline flushes.

## Interface
- `ADDR_W`, default 32: address width of va/pa and cache op address.
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: EXE holds a valid CACOP (level, held until `cacop_ok`).
- `req_code` in 5: CACOP code; [2:0] target, [4:3] operation.
- `req_va` in ADDR_W: virtual address (ALU result).
- `req_pa` in ADDR_W: translated physical address.
- `req_tlb_exc` in 1: translation fault detected for this request.
- `flush` in 1: MEM/WB exception (ms_ex | wb_ex) this cycle.
- `ic_op_valid` out 1, `ic_op` out 2, `ic_op_addr` out ADDR_W: icache maintenance request.
- `ic_op_ready` in 1, `ic_op_done` in 1: icache accept / completion pulse.
- `dc_op_valid` out 1, `dc_op` out 2, `dc_op_addr` out ADDR_W: dcache maintenance request.
- `dc_op_ready` in 1, `dc_op_done` in 1: dcache accept / completion pulse.
- `cacop_ok` out 1: one-cycle completion to EXE.
- `busy` out 1: state != IDLE.
- `ops_done_cnt` out CNT_W: count of completed (non-flushed) operations, wraps.

## Operation
- Decode:
  - Target 0 = icache, 1 = dcache, 2..7 = no-op.
  - Op 00 = store-tag, 01 = index-invalidate, 10 = hit-invalidate, 11 = no-op.
  - `ic_op`/`dc_op` carry the op field unchanged.
- Address: store-tag and index-invalidate use latched va; hit-invalidate uses latched pa.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - `req_valid & ~flush` latches code, va, pa, tlb_exc.
  - Goes to DONE if the request is a no-op, or is a hit-invalidate with `req_tlb_exc` (nothing issued; the exception is handled downstream).
  - Otherwise goes to ISSUE.
- ISSUE:
  - Asserts the selected `*_op_valid` with its op and address; the other port stays 0.
  - `flush` → IDLE, no issue counted.
  - Else `*_op_ready` → WAIT.
  - Outputs hold stable until ready.
- WAIT:
  - Selected `*_op_done` → DONE, unless `flush` is seen at or before done.
  - In that case go to DRAIN if done has not yet arrived, or to IDLE if done arrives in the flush cycle.
  - Done from the non-selected cache is ignored.
- DRAIN: wait for the selected `*_op_done` → IDLE, with no `cacop_ok` and no count.
- DONE:
  - `cacop_ok = ~flush`; `ops_done_cnt` increments when `cacop_ok` is asserted.
  - Always → IDLE next cycle.
  - `req_valid` in the DONE cycle is the same instruction and is ignored.
- `req_valid` is ignored in every state except IDLE.
- `ops_done_cnt` wraps from 2^CNT_W-1 to 0.

## Timing
- Reset:
  - state = IDLE.
  - All outputs 0: `*_op_valid`, `*_op`, `*_op_addr`, `cacop_ok`, `busy`, `ops_done_cnt`.
  - Latched fields cleared.
- `*_op_valid`, `*_op`, `*_op_addr`, `busy` are driven from state and registers only, with no combinational path from inputs.
- `cacop_ok` is state-decoded and gated combinationally by `flush`.
- Issued op, accepted at T (IDLE):
  - ISSUE at T+1.
  - If ready at T+1 → WAIT at T+2.
  - Done at T+2 at the earliest → `cacop_ok` at T+3.
  - Minimum latency is 3 cycles; each ready/done stall adds 1 cycle.
- No-op or faulted hit-invalidate accepted at T: `cacop_ok` at T+1.
- Simultaneous `flush` and `req_valid` in IDLE: not accepted.
- Reset mid-operation returns to IDLE immediately; the cache side is reset concurrently, so no drain is required.
- Back-to-back CACOPs: the next request is accepted in IDLE at the cycle after DONE, giving a 4-cycle minimum spacing.

## Test plan
- dcache index-invalidate (code 01001), va=0x1C000040, pa=0x00000040, ready and done each the next cycle → `dc_op_valid` 1 cycle with op=01, addr=0x1C000040; `cacop_ok` at T+3; count=1; `ic_op_valid` never high.
- icache hit-invalidate (10000), va=0xA0001000, pa=0x00001000, ready held low 3 cycles → `ic_op_valid` held stable 4 cycles with addr=0x00001000, op=10; `cacop_ok` once.
- Hit-invalidate (10001) with `req_tlb_exc`=1 → no `dc_op_valid`; `cacop_ok` at T+1.
- Code 00111 (no-op target) → `cacop_ok` at T+1, no cache request; code 11000 behaves the same.
- Flush in WAIT, done 5 cycles later → state DRAIN, `busy` stays high until done, no `cacop_ok`; count unchanged; a new `req_valid` during DRAIN is not accepted until IDLE.
- Reset asserted in WAIT → next cycle all outputs 0; `ops_done_cnt` preset near max then 2 completions → wraps to 0 then 1.

Source files
------------

// File: rtl/cacop_ctrl.sv
// -----------------------------------------------------------------------------
// cacop_ctrl
//
// Sequencer for CACOP cache-maintenance operations coming from EXE. A request
// is captured in IDLE, decoded into a target cache (icache / dcache / none) and
// an operation (store-tag / index-invalidate / hit-invalidate / none), issued
// as one valid/ready handshake on the selected maintenance port, and completed
// once that cache reports done. EXE is released by a one-cycle cacop_ok_o.
// A MEM/WB flush abandons the request; an operation that is already accepted
// by a cache is drained before another request can start.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_valid_i             EXE holds a CACOP (level, until cacop_ok_o)
//   req_code_i[4:0]         [2:0] target, [4:3] operation
//   req_va_i, req_pa_i      virtual / translated physical address
//   req_tlb_exc_i           translation fault for this request
//   flush_i                 MEM/WB exception this cycle
//   ic_op_valid_o/_o/_addr_o, ic_op_ready_i, ic_op_done_i   icache port
//   dc_op_valid_o/_o/_addr_o, dc_op_ready_i, dc_op_done_i   dcache port
//   cacop_ok_o              one-cycle completion to EXE (gated by flush_i)
//   busy_o                  sequencer not in IDLE
//   ops_done_cnt_o          completed, non-flushed operations (wraps)
// -----------------------------------------------------------------------------
module cacop_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  input  logic [4:0]        req_code_i,
  input  logic [ADDR_W-1:0] req_va_i,
  input  logic [ADDR_W-1:0] req_pa_i,
  input  logic              req_tlb_exc_i,
  input  logic              flush_i,
  output logic              ic_op_valid_o,
  output logic [1:0]        ic_op_o,
  output logic [ADDR_W-1:0] ic_op_addr_o,
  input  logic              ic_op_ready_i,
  input  logic              ic_op_done_i,
  output logic              dc_op_valid_o,
  output logic [1:0]        dc_op_o,
  output logic [ADDR_W-1:0] dc_op_addr_o,
  input  logic              dc_op_ready_i,
  input  logic              dc_op_done_i,
  output logic              cacop_ok_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  ops_done_cnt_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam logic [2:0] TGT_IC     = 3'd0;
  localparam logic [2:0] TGT_DC     = 3'd1;
  localparam logic [1:0] OP_HIT_INV = 2'b10;
  localparam logic [1:0] OP_NOP     = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_e              state_q;
  logic [4:0]          code_q;
  logic [ADDR_W-1:0]   va_q;
  logic [ADDR_W-1:0]   pa_q;
  logic                tlb_exc_q;
  logic [CNT_W-1:0]    cnt_q;

  // decode of the incoming request (used only for the IDLE decision)
  logic                req_is_ic;
  logic                req_is_dc;
  logic                req_skip;

  // decode of the latched request (drives the ports and the handshakes)
  logic [1:0]          lat_op;
  logic                lat_hit;
  logic                lat_ic;
  logic                lat_dc;
  logic [ADDR_W-1:0]   lat_addr;
  logic                sel_ready;
  logic                sel_done;

  // Incoming request decode: a request is skipped (straight to DONE) when it
  // targets no cache, is a no-op, or is a hit-invalidate whose translation
  // faulted; the fault is taken downstream so nothing must reach the cache.
  always_comb begin
    req_is_ic = (req_code_i[2:0] == TGT_IC) && (req_code_i[4:3] != OP_NOP);
    req_is_dc = (req_code_i[2:0] == TGT_DC) && (req_code_i[4:3] != OP_NOP);
    req_skip  = !(req_is_ic || req_is_dc) ||
                ((req_code_i[4:3] == OP_HIT_INV) && req_tlb_exc_i);
  end

  // Latched request decode. The fault term is repeated here so that a faulted
  // hit-invalidate can never be presented to a cache, whatever the path taken.
  always_comb begin
    lat_op    = code_q[4:3];
    lat_hit   = (lat_op == OP_HIT_INV);
    lat_ic    = (code_q[2:0] == TGT_IC) && (lat_op != OP_NOP) && !(lat_hit && tlb_exc_q);
    lat_dc    = (code_q[2:0] == TGT_DC) && (lat_op != OP_NOP) && !(lat_hit && tlb_exc_q);
    lat_addr  = lat_hit ? pa_q : va_q;
    sel_ready = lat_ic ? ic_op_ready_i : (lat_dc ? dc_op_ready_i : 1'b0);
    sel_done  = lat_ic ? ic_op_done_i  : (lat_dc ? dc_op_done_i  : 1'b0);
  end

  // Main sequencer: state, latched request fields and completion counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      code_q    <= 5'b00000;
      va_q      <= ADDR_ZERO;
      pa_q      <= ADDR_ZERO;
      tlb_exc_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          // a request coinciding with a flush belongs to a killed instruction
          if (req_valid_i && !flush_i) begin
            code_q    <= req_code_i;
            va_q      <= req_va_i;
            pa_q      <= req_pa_i;
            tlb_exc_q <= req_tlb_exc_i;
            state_q   <= req_skip ? DONE : ISSUE;
          end else begin
            state_q   <= IDLE;
          end
        end
        ISSUE: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (!(lat_ic || lat_dc)) begin
            // nothing selected: unreachable, recover rather than hang
            state_q <= IDLE;
          end else if (sel_ready) begin
            state_q <= WAIT;
          end else begin
            state_q <= ISSUE;
          end
        end
        WAIT: begin
          // done and flush together: the op finished, nothing left to drain
          if (sel_done) begin
            state_q <= flush_i ? IDLE : DONE;
          end else if (flush_i) begin
            state_q <= DRAIN;
          end else begin
            state_q <= WAIT;
          end
        end
        DONE: begin
          if (!flush_i) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            cnt_q <= cnt_q;
          end
          state_q <= IDLE;
        end
        DRAIN: begin
          if (sel_done) begin
            state_q <= IDLE;
          end else begin
            state_q <= DRAIN;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Port outputs come only from the state register and latched fields, so the
  // request stays stable while ISSUE waits for ready.
  always_comb begin
    ic_op_valid_o  = (state_q == ISSUE) && lat_ic;
    dc_op_valid_o  = (state_q == ISSUE) && lat_dc;
    ic_op_o        = ic_op_valid_o ? lat_op : 2'b00;
    dc_op_o        = dc_op_valid_o ? lat_op : 2'b00;
    ic_op_addr_o   = ic_op_valid_o ? lat_addr : ADDR_ZERO;
    dc_op_addr_o   = dc_op_valid_o ? lat_addr : ADDR_ZERO;
    busy_o         = (state_q != IDLE);
    cacop_ok_o     = (state_q == DONE) && !flush_i;
    ops_done_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_cacop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cacop_ctrl
//
// Cycle-table bench for cacop_ctrl: each table row is the input set applied for
// one cycle plus the outputs expected during that cycle. Reset mid-operation
// and counter wrap are exercised by hand-written sequences afterwards.
// -----------------------------------------------------------------------------
module tb_cacop_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [4:0]    req_code;
  logic [AW-1:0] req_va;
  logic [AW-1:0] req_pa;
  logic          req_tlb_exc;
  logic          flush;
  logic          ic_op_valid;
  logic [1:0]    ic_op;
  logic [AW-1:0] ic_op_addr;
  logic          ic_op_ready;
  logic          ic_op_done;
  logic          dc_op_valid;
  logic [1:0]    dc_op;
  logic [AW-1:0] dc_op_addr;
  logic          dc_op_ready;
  logic          dc_op_done;
  logic          cacop_ok;
  logic          busy;
  logic [CW-1:0] ops_done_cnt;

  always #5 clk = ~clk;

  cacop_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_code_i     (req_code),
    .req_va_i       (req_va),
    .req_pa_i       (req_pa),
    .req_tlb_exc_i  (req_tlb_exc),
    .flush_i        (flush),
    .ic_op_valid_o  (ic_op_valid),
    .ic_op_o        (ic_op),
    .ic_op_addr_o   (ic_op_addr),
    .ic_op_ready_i  (ic_op_ready),
    .ic_op_done_i   (ic_op_done),
    .dc_op_valid_o  (dc_op_valid),
    .dc_op_o        (dc_op),
    .dc_op_addr_o   (dc_op_addr),
    .dc_op_ready_i  (dc_op_ready),
    .dc_op_done_i   (dc_op_done),
    .cacop_ok_o     (cacop_ok),
    .busy_o         (busy),
    .ops_done_cnt_o (ops_done_cnt)
  );

  typedef struct {
    logic          rv;
    logic [4:0]    code;
    logic [AW-1:0] va;
    logic [AW-1:0] pa;
    logic          tlb;
    logic          fl;
    logic [3:0]    hs;   // {ic_ready, ic_done, dc_ready, dc_done}
    logic [2:0]    icx;  // {ic_op_valid, ic_op}
    logic [AW-1:0] ica;
    logic [2:0]    dcx;  // {dc_op_valid, dc_op}
    logic [AW-1:0] dca;
    logic          ok;
    logic          bsy;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic          F   = 1'b0;
  localparam logic          T   = 1'b1;
  localparam logic [AW-1:0] Z   = 32'h0000_0000;
  localparam logic [AW-1:0] VA1 = 32'h1C00_0040;
  localparam logic [AW-1:0] PA1 = 32'h0000_0040;
  localparam logic [AW-1:0] VA2 = 32'hA000_1000;
  localparam logic [AW-1:0] PA2 = 32'h0000_1000;
  localparam logic [4:0]    C1  = 5'b01001;  // dcache index-invalidate
  localparam logic [4:0]    C2  = 5'b10000;  // icache hit-invalidate
  localparam logic [4:0]    C3  = 5'b10001;  // dcache hit-invalidate
  localparam logic [4:0]    C4  = 5'b00000;  // icache store-tag
  localparam logic [4:0]    CN  = 5'b00111;  // no-op target
  localparam logic [4:0]    CX  = 5'b11000;  // no-op operation
  localparam logic [2:0]    NI  = 3'b000;
  localparam logic [2:0]    DC1 = 3'b101;
  localparam logic [2:0]    IC2 = 3'b110;
  localparam logic [2:0]    IC0 = 3'b100;

  function automatic vec_t v(input logic rv, input logic [4:0] code,
                             input logic [AW-1:0] va, input logic [AW-1:0] pa,
                             input logic tlb, input logic fl, input logic [3:0] hs,
                             input logic [2:0] icx, input logic [AW-1:0] ica,
                             input logic [2:0] dcx, input logic [AW-1:0] dca,
                             input logic ok, input logic bsy, input logic [CW-1:0] cnt);
    vec_t r;
    r.rv = rv; r.code = code; r.va = va; r.pa = pa; r.tlb = tlb; r.fl = fl; r.hs = hs;
    r.icx = icx; r.ica = ica; r.dcx = dcx; r.dca = dca; r.ok = ok; r.bsy = bsy; r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [127:0] outs();
    logic [127:0] r;
    r = 128'h0;
    r[75:0] = {ic_op_valid, ic_op, ic_op_addr, dc_op_valid, dc_op, dc_op_addr,
               cacop_ok, busy, ops_done_cnt};
    return r;
  endfunction

  function automatic logic [127:0] exp_outs(input vec_t x);
    logic [127:0] r;
    r = 128'h0;
    r[75:0] = {x.icx, x.ica, x.dcx, x.dca, x.ok, x.bsy, x.cnt};
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    req_valid   = x.rv;
    req_code    = x.code;
    req_va      = x.va;
    req_pa      = x.pa;
    req_tlb_exc = x.tlb;
    flush       = x.fl;
    {ic_op_ready, ic_op_done, dc_op_ready, dc_op_done} = x.hs;
  endtask

  // one no-op CACOP starting at posedge+1; returns cacop_ok seen in DONE
  task automatic noop_op(output logic ok_seen);
    req_valid = 1'b1;
    req_code  = CN;
    @(posedge clk); #1;
    ok_seen   = cacop_ok;
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic ok_s;

    // reset state
    vq.push_back(v(F,CN,Z,Z,F,F,4'h0, NI,Z,NI,Z, F,F,4'd0));
    // dcache index-invalidate, ready and done at the earliest
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd0));
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h2, NI,Z,DC1,VA1, F,T,4'd0));
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h1, NI,Z,NI,Z,   F,T,4'd0));
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   T,T,4'd0));
    vq.push_back(v(F,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd1));
    // icache hit-invalidate, ready low for 3 cycles, stray dcache done
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd1));
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h0, IC2,PA2,NI,Z, F,T,4'd1));
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h0, IC2,PA2,NI,Z, F,T,4'd1));
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h0, IC2,PA2,NI,Z, F,T,4'd1));
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h8, IC2,PA2,NI,Z, F,T,4'd1));
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h1, NI,Z,NI,Z,   F,T,4'd1));
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h4, NI,Z,NI,Z,   F,T,4'd1));
    vq.push_back(v(T,C2,VA2,PA2,F,F,4'h0, NI,Z,NI,Z,   T,T,4'd1));
    vq.push_back(v(F,C2,VA2,PA2,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd2));
    // faulted hit-invalidate: nothing issued
    vq.push_back(v(T,C3,VA2,PA2,T,F,4'h0, NI,Z,NI,Z,   F,F,4'd2));
    vq.push_back(v(T,C3,VA2,PA2,T,F,4'h0, NI,Z,NI,Z,   T,T,4'd2));
    vq.push_back(v(F,C3,VA2,PA2,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd3));
    // no-op codes, back to back
    vq.push_back(v(T,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd3));
    vq.push_back(v(T,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   T,T,4'd3));
    vq.push_back(v(T,CX,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd4));
    vq.push_back(v(T,CX,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   T,T,4'd4));
    vq.push_back(v(F,CX,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd5));
    // request together with flush in IDLE is not accepted
    vq.push_back(v(T,C1,VA1,PA1,F,T,4'h0, NI,Z,NI,Z,   F,F,4'd5));
    vq.push_back(v(F,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd5));
    // flush in WAIT, done 5 cycles later; new request held through DRAIN
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd5));
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h2, NI,Z,DC1,VA1, F,T,4'd5));
    vq.push_back(v(F,C1,VA1,PA1,F,T,4'h0, NI,Z,NI,Z,   F,T,4'd5));
    for (int k = 0; k < 4; k++) begin
      vq.push_back(v(T,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z, F,T,4'd5));
    end
    vq.push_back(v(T,CN,VA1,PA1,F,F,4'h1, NI,Z,NI,Z,   F,T,4'd5));
    vq.push_back(v(T,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd5));
    vq.push_back(v(T,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   T,T,4'd5));
    vq.push_back(v(F,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    // flush in DONE suppresses cacop_ok and the count
    vq.push_back(v(T,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    vq.push_back(v(T,CN,VA1,PA1,F,T,4'h0, NI,Z,NI,Z,   F,T,4'd6));
    vq.push_back(v(F,CN,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    // flush in ISSUE (with ready) returns to IDLE
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    vq.push_back(v(T,C1,VA1,PA1,F,T,4'h2, NI,Z,DC1,VA1, F,T,4'd6));
    vq.push_back(v(F,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    // flush in the same cycle as done: straight to IDLE, no ok
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    vq.push_back(v(T,C1,VA1,PA1,F,F,4'h2, NI,Z,DC1,VA1, F,T,4'd6));
    vq.push_back(v(F,C1,VA1,PA1,F,T,4'h1, NI,Z,NI,Z,   F,T,4'd6));
    vq.push_back(v(F,C1,VA1,PA1,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    // icache store-tag uses the virtual address
    vq.push_back(v(T,C4,VA2,PA2,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd6));
    vq.push_back(v(T,C4,VA2,PA2,F,F,4'h8, IC0,VA2,NI,Z, F,T,4'd6));
    vq.push_back(v(T,C4,VA2,PA2,F,F,4'h4, NI,Z,NI,Z,   F,T,4'd6));
    vq.push_back(v(T,C4,VA2,PA2,F,F,4'h0, NI,Z,NI,Z,   T,T,4'd6));
    vq.push_back(v(F,C4,VA2,PA2,F,F,4'h0, NI,Z,NI,Z,   F,F,4'd7));

    reset = 1'b1;
    drive(v(F,CN,Z,Z,F,F,4'h0, NI,Z,NI,Z, F,F,4'd0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(negedge clk);
      check($sformatf("row%0d", i), outs(), exp_outs(vq[i]));
      @(posedge clk); #1;
    end

    // reset asserted while waiting for done
    req_valid = 1'b1; req_code = C1; req_va = VA1; req_pa = PA1;
    @(posedge clk); #1;
    dc_op_ready = 1'b1;
    @(posedge clk); #1;
    dc_op_ready = 1'b0;
    @(negedge clk);
    check("wait_busy", {127'h0, busy}, {127'h0, 1'b1});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("reset_in_wait", outs(), 128'h0);
    @(posedge clk); #1;

    // counter wrap: 15 completions to the maximum, then two more
    for (int k = 0; k < 15; k++) begin
      noop_op(ok_s);
    end
    check("cnt_max", {124'h0, ops_done_cnt}, {124'h0, 4'd15});
    noop_op(ok_s);
    check("wrap_ok1", {127'h0, ok_s}, {127'h0, 1'b1});
    check("cnt_wrap0", {124'h0, ops_done_cnt}, {124'h0, 4'd0});
    noop_op(ok_s);
    check("wrap_ok2", {127'h0, ok_s}, {127'h0, 1'b1});
    check("cnt_wrap1", {124'h0, ops_done_cnt}, {124'h0, 4'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
